// File: rtl/sap_io_pkg.sv
// Shared defaults and entry type for the SAP-2 I/O bridge.
// Optional drop counter is enabled by defining SAP_IO_DROP_CNT_EN.
package sap_io_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int NUM_PORTS_DEF  = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    // A single output port still needs a 1-bit index field.
    function automatic int port_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    localparam int PORT_W_DEF = port_w(NUM_PORTS_DEF);

    typedef struct packed {
        logic [PORT_W_DEF-1:0] port;
        logic [DATA_W_DEF-1:0] data;
    } io_entry_t;

endpackage

// File: rtl/sap_io_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
// Latency: push visible at head one cycle later, no bypass.
// Backpressure: push while full and pop while empty are ignored.
module sap_io_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = CNT_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sap_io_bridge.sv
// SAP-2 core to pad bridge: queued OUT writes to per-port registers, synchronised IN reads.
// Latency: write to out_valid 1 cycle; pad input to rd_data 2 sync cycles plus 1 at rd_en.
// Backpressure: out_ready stalls the queue, cpu_stall when full. SAP_IO_DROP_CNT_EN adds drop_cnt.
module sap_io_bridge
    import sap_io_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_PORTS  = NUM_PORTS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                wr_en,
    input  logic [port_w(NUM_PORTS)-1:0]        wr_port,
    input  logic [DATA_W-1:0]                   wr_data,
    output logic                                cpu_stall,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [port_w(NUM_PORTS)-1:0]        out_port,
    output logic [DATA_W-1:0]                   out_data,
    output logic [NUM_PORTS*DATA_W-1:0]         port_q,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
    input  logic [DATA_W-1:0]                   in_pins,
    input  logic                                rd_en,
    output logic [DATA_W-1:0]                   rd_data,
    output logic                                rd_valid
`ifdef SAP_IO_DROP_CNT_EN
    ,
    output logic [7:0]                          drop_cnt
`endif
);

    localparam int PORT_W = port_w(NUM_PORTS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            wr_ent;
    entry_t            head_ent;
    logic              full;
    logic              empty;
    logic              pop;
    logic [DATA_W-1:0] sync1;
    logic [DATA_W-1:0] sync2;

    assign wr_ent.port = wr_port;
    assign wr_ent.data = wr_data;

    sap_io_fifo #(
        .WIDTH (PORT_W + DATA_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (wr_en),
        .push_dat (wr_ent),
        .pop      (pop),
        .head     (head_ent),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    assign cpu_stall = full;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // Storage is not reset, so the head is masked to keep outputs at zero while empty.
    assign out_port  = empty ? '0 : head_ent.port;
    assign out_data  = empty ? '0 : head_ent.data;

    // Out-of-range port indices are delivered on out_* but touch no holding register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            port_q <= '0;
        end else if (pop) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (int'(out_port) == p) begin
                    port_q[p*DATA_W +: DATA_W] <= out_data;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1    <= '0;
            sync2    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            sync1    <= in_pins;
            sync2    <= sync1;
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= sync2;
            end
        end
    end

`ifdef SAP_IO_DROP_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_cnt <= '0;
        end else if (wr_en && full && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sap_io_bridge.sv
// Directed bench for sap_io_bridge: reset, vector table for queue behaviour, input path, back-pressure.
module tb_sap_io_bridge;
    import sap_io_pkg::*;

    logic        CLK       = 1'b0;
    logic        RST       = 1'b1;
    logic        wr_en     = 1'b0;
    logic [0:0]  wr_port   = '0;
    logic [7:0]  wr_data   = '0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_pins   = '0;
    logic        rd_en     = 1'b0;
    logic        cpu_stall;
    logic        out_valid;
    logic [0:0]  out_port;
    logic [7:0]  out_data;
    logic [15:0] port_q;
    logic [2:0]  fifo_count;
    logic [7:0]  rd_data;
    logic        rd_valid;
`ifdef SAP_IO_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    sap_io_bridge dut (
        .CLK        (CLK),
        .RST        (RST),
        .wr_en      (wr_en),
        .wr_port    (wr_port),
        .wr_data    (wr_data),
        .cpu_stall  (cpu_stall),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_port   (out_port),
        .out_data   (out_data),
        .port_q     (port_q),
        .fifo_count (fifo_count),
        .in_pins    (in_pins),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
`ifdef SAP_IO_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic        port;
        logic [7:0]  data;
        logic        rdy;
        logic        e_valid;
        logic        e_port;
        logic [7:0]  e_data;
        logic [2:0]  e_cnt;
        logic        e_stall;
        logic [15:0] e_q;
    } vec_t;

    vec_t      vecs [14];
    io_entry_t mq [$];
    io_entry_t ent;
    logic [15:0] m_port_q;
    int  sent;
    int  cyc;
    logic r;
    logic do_w;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " fifo_count"}, 32'(fifo_count), 0);
        chk({tag, " out_valid"},  32'(out_valid),  0);
        chk({tag, " cpu_stall"},  32'(cpu_stall),  0);
        chk({tag, " out_port"},   32'(out_port),   0);
        chk({tag, " out_data"},   32'(out_data),   0);
        chk({tag, " port_q"},     32'(port_q),     0);
        chk({tag, " rd_data"},    32'(rd_data),    0);
        chk({tag, " rd_valid"},   32'(rd_valid),   0);
`ifdef SAP_IO_DROP_CNT_EN
        chk({tag, " drop_cnt"},   32'(drop_cnt),   0);
`endif
    endtask

    initial begin
        //          we port data   rdy  val oprt odata cnt stall q
        vecs[0]  = '{1, 1, 8'hA5, 1,   1,  1, 8'hA5, 1, 0, 16'h0000};
        vecs[1]  = '{0, 0, 8'h00, 1,   0,  0, 8'h00, 0, 0, 16'hA500};
        vecs[2]  = '{1, 0, 8'h01, 0,   1,  0, 8'h01, 1, 0, 16'hA500};
        vecs[3]  = '{1, 0, 8'h02, 0,   1,  0, 8'h01, 2, 0, 16'hA500};
        vecs[4]  = '{1, 0, 8'h03, 0,   1,  0, 8'h01, 3, 0, 16'hA500};
        vecs[5]  = '{1, 0, 8'h04, 0,   1,  0, 8'h01, 4, 1, 16'hA500};
        vecs[6]  = '{1, 0, 8'h05, 0,   1,  0, 8'h01, 4, 1, 16'hA500};
        vecs[7]  = '{1, 0, 8'h06, 1,   1,  0, 8'h02, 3, 0, 16'hA501};
        vecs[8]  = '{1, 1, 8'h07, 1,   1,  0, 8'h03, 3, 0, 16'hA502};
        vecs[9]  = '{0, 0, 8'h00, 1,   1,  0, 8'h04, 2, 0, 16'hA503};
        vecs[10] = '{1, 0, 8'h08, 1,   1,  1, 8'h07, 2, 0, 16'hA504};
        vecs[11] = '{1, 1, 8'h09, 1,   1,  0, 8'h08, 2, 0, 16'h0704};
        vecs[12] = '{0, 0, 8'h00, 1,   1,  1, 8'h09, 1, 0, 16'h0708};
        vecs[13] = '{0, 0, 8'h00, 1,   0,  0, 8'h00, 0, 0, 16'h0908};

        // Reset held from time zero
        #12;
        chk_all_zero("reset");
        @(negedge CLK);
        RST = 1'b0;

        // Input synchroniser: two sync cycles then a one-cycle read strobe
        @(negedge CLK);
        in_pins = 8'h3C;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        rd_en = 1'b1;
        @(posedge CLK); #1;
        chk("rd_data 3C", 32'(rd_data), 32'h3C);
        chk("rd_valid pulse", 32'(rd_valid), 1);
        @(negedge CLK);
        rd_en = 1'b0;
        @(posedge CLK); #1;
        chk("rd_valid drop", 32'(rd_valid), 0);
        chk("rd_data hold", 32'(rd_data), 32'h3C);

        // New pad value reaches rd_data only on the third edge
        @(negedge CLK);
        in_pins = 8'hC3;
        rd_en   = 1'b1;
        @(posedge CLK); #1;
        chk("sync lat e1", 32'(rd_data), 32'h3C);
        @(posedge CLK); #1;
        chk("sync lat e2", 32'(rd_data), 32'h3C);
        @(posedge CLK); #1;
        chk("sync lat e3", 32'(rd_data), 32'hC3);
        @(negedge CLK);
        rd_en = 1'b0;

        // Load state, then reset asynchronously between edges
        wr_en = 1'b1; wr_port = 1'b0; wr_data = 8'h11; out_ready = 1'b0;
        @(negedge CLK);
        wr_en = 1'b0; out_ready = 1'b1;
        @(negedge CLK);
        wr_en = 1'b1; wr_data = 8'h22; out_ready = 1'b0;
        @(negedge CLK);
        wr_data = 8'h33;
        @(negedge CLK);
        wr_en = 1'b0;
        chk("pre-rst port_q", 32'(port_q), 32'h0011);
        chk("pre-rst count", 32'(fifo_count), 2);
        #2;
        RST = 1'b1;
        #1;
        chk_all_zero("async rst");
        @(negedge CLK);
        RST = 1'b0;

        // Vector table: single write, fill/overflow, push+pop, ordered drain
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            wr_en     = vecs[i].we;
            wr_port   = vecs[i].port;
            wr_data   = vecs[i].data;
            out_ready = vecs[i].rdy;
            @(posedge CLK); #1;
            chk($sformatf("v%0d out_valid", i),  32'(out_valid),  32'(vecs[i].e_valid));
            chk($sformatf("v%0d out_port", i),   32'(out_port),   32'(vecs[i].e_port));
            chk($sformatf("v%0d out_data", i),   32'(out_data),   32'(vecs[i].e_data));
            chk($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d cpu_stall", i),  32'(cpu_stall),  32'(vecs[i].e_stall));
            chk($sformatf("v%0d port_q", i),     32'(port_q),     32'(vecs[i].e_q));
        end
        @(negedge CLK);
        wr_en = 1'b0; out_ready = 1'b0;
`ifdef SAP_IO_DROP_CNT_EN
        chk("drop_cnt after overflow", 32'(drop_cnt), 2);
`endif

        // Random back-pressure over 20 words with a reference queue
        m_port_q = 16'h0908;
        sent = 0;
        cyc  = 0;
        while ((sent < 20 || mq.size() > 0) && cyc < 500) begin
            @(negedge CLK);
            chk("bp out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("bp fifo_count", 32'(fifo_count), 32'(mq.size()));
            if (mq.size() > 0) begin
                chk("bp out_port", 32'(out_port), 32'(mq[0].port));
                chk("bp out_data", 32'(out_data), 32'(mq[0].data));
            end
            r         = 1'($urandom_range(0, 1));
            do_w      = (sent < 20) && (mq.size() < 4);
            out_ready = r;
            wr_en     = do_w;
            wr_port   = 1'($urandom_range(0, 1));
            wr_data   = 8'h40 + 8'(sent);
            @(posedge CLK);
            if (r && mq.size() > 0) begin
                ent = mq.pop_front();
                m_port_q[ent.port*8 +: 8] = ent.data;
            end
            if (do_w) begin
                ent.port = wr_port;
                ent.data = wr_data;
                mq.push_back(ent);
                sent++;
            end
            cyc++;
        end
        if (cyc >= 500) begin
            chk("bp timeout", 32'(cyc), 0);
        end
        @(negedge CLK);
        wr_en = 1'b0; out_ready = 1'b0;
        chk("bp port_q", 32'(port_q), 32'(m_port_q));
        chk("bp empty", 32'(fifo_count), 0);
`ifdef SAP_IO_DROP_CNT_EN
        chk("bp drop_cnt", 32'(drop_cnt), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_io_bridge.md
# sap_io_bridge

Parametrised I/O bridge between the SAP-2 core and the chip pads, the successor to the fixed one-register output path. The core's OUT instruction writes a data word with a port index into a shared FIFO. The FIFO drains to the pad side over a valid/ready handshake and updates a per-port holding register. The core's IN instruction samples synchronised pad inputs.

## Interface
- `DATA_W`, 8: bus/data width in bits
- `NUM_PORTS`, 2: number of output ports (≥1); `PORT_W = max(1, $clog2(NUM_PORTS))`
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2); `CNT_W = $clog2(FIFO_DEPTH)+1`

- `CLK` in 1: single clock, all flops rising-edge
- `RST` in 1: asynchronous, active-high reset
- `wr_en` in 1: core OUT strobe, one cycle per write
- `wr_port` in PORT_W: target output port
- `wr_data` in DATA_W: word from core bus
- `cpu_stall` out 1: FIFO full; controller holds the OUT step
- `out_valid` out 1: FIFO head valid
- `out_ready` in 1: pad-side consumer accepts head
- `out_port` out PORT_W: head port index
- `out_data` out DATA_W: head data
- `port_q` out NUM_PORTS*DATA_W: last delivered value per port, port 0 in LSBs
- `fifo_count` out CNT_W: current occupancy
- `in_pins` in DATA_W: asynchronous pad inputs
- `rd_en` in 1: core IN strobe
- `rd_data` out DATA_W: sampled input word
- `rd_valid` out 1: one-cycle pulse, `rd_data` updated

## Operation
- Reset, asynchronous: FIFO empty, pointers 0, `fifo_count`=0, `out_valid`=0, `cpu_stall`=0, `out_port`/`out_data`=0, `port_q`=0, sync flops=0, `rd_data`=0, `rd_valid`=0. Asserting RST mid-transfer discards all FIFO contents.
- Push: on `wr_en` && !full, store {wr_port, wr_data} at the write pointer.
- A write while full is dropped, even if a pop happens in the same cycle. Full is evaluated on the pre-edge state.
- `wr_port` ≥ NUM_PORTS: the entry is queued and delivered on `out_*`. `port_q` is not updated.
- Pop: on `out_valid && out_ready`, advance the read pointer and copy `out_data` into `port_q[out_port]`.
- Simultaneous push and pop when not full: the count is unchanged and both take effect.
- Pointers are CNT_W bits and wrap modulo 2·FIFO_DEPTH. full = MSBs differ and the low bits are equal; empty = pointers equal.
- `cpu_stall` = full and `out_valid` = !empty, both combinational from registered state.
- `out_port` and `out_data` are the head entry and are held stable while `out_valid` && !`out_ready`.
- Input: `in_pins` passes through a 2-flop synchroniser. On `rd_en`, `rd_data` <= synchronised value and `rd_valid` pulses for 1 cycle. Without `rd_en`, `rd_data` holds.

## Timing
- Write-to-`out_valid`: 1 cycle, with no bypass. A write at edge N is visible after edge N.
- Pop-to-`port_q` update: the same edge as the handshake.
- `in_pins`-to-`rd_data`: 2 cycles of synchroniser latency plus 1 cycle at `rd_en`.
- `cpu_stall` deasserts in the cycle after the pop that frees a slot.

## Configuration
- `SAP_IO_DROP_CNT_EN` defined: adds output `drop_cnt` [7:0]. It increments on every dropped write (`wr_en` && full), saturates at 255, and resets to 0.
- Not defined: the port and counter are absent and drops are silent.

## Structure
- Package `sap_io_pkg`: default parameter constants, and typedef `io_entry_t` struct {port, data} sized from the package defaults.
- Sub-module `sap_io_fifo`: a generic synchronous FIFO with push/pop/full/empty/count. The bridge adds port routing, `port_q`, the input synchroniser and the drop counter.

## Test plan
- Reset: assert RST asynchronously between edges. All outputs go to 0 immediately and `out_valid`=0.
- Single write: `wr_port`=1, `wr_data`=0xA5, with `out_ready`=1. `out_valid` is high the next cycle with `out_port`=1 and `out_data`=0xA5. After the pop, `port_q[15:8]`=0xA5 and `port_q[7:0]`=0x00.
- Fill and overflow: `out_ready`=0 and 5 writes 0x01..0x05. `fifo_count`=4 and `cpu_stall`=1. 0x05 is dropped and `drop_cnt`=1 when the macro is defined. Draining yields 0x01..0x04 in order.
- Simultaneous push and pop at count=2: `fifo_count` stays 2 and order is preserved. A write in the full state concurrent with a pop is dropped.
- Back-pressure: `out_ready` toggled randomly. `out_port` and `out_data` are stable while stalled, with no loss or duplication across 20 words spanning pointer wrap.
- Input: `in_pins`=0x3C, then pulse `rd_en` after 2 cycles. `rd_data`=0x3C and `rd_valid` is high for exactly 1 cycle.
